// File: rtl/tmp_readout_pkg.sv
// Shared types and constants for the temperature-sensor readout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tmp_readout_pkg;

    // Default conversion window, in packets (source + sink).
    localparam int TMP_WINDOW = 256;

    // Code width that holds 0..window inclusive.
    function automatic int tmp_code_w(input int window);
        return $clog2(window + 1);
    endfunction

    localparam int TMP_CODE_W = tmp_code_w(TMP_WINDOW);

    // Buffered result at the default window size.
    typedef struct packed {
        logic [3:0]            seq;
        logic [TMP_CODE_W-1:0] code;
    } tmp_entry_t;

endpackage

// File: rtl/tmp_readout_fifo.sv
// 2-entry first-word-fall-through buffer for completed readout entries.
// Latency: a push is visible on o_dat the cycle after it is written; no bubble between entries.
// Backpressure: the caller must not push when full unless it pops in the same cycle.
//   clk, reset      : clock, asynchronous active-high reset
//   i_push, i_dat   : write strobe and data
//   i_pop           : consume the head entry
//   o_dat           : head entry
//   o_full, o_empty : occupancy flags
module tmp_readout_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_dat,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_cnt;

    // When full, the write slot equals the read slot; a simultaneous push
    // and pop overwrites the head only after it has been consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_dat   = r_mem[r_rd_ptr];
    assign o_full  = (r_cnt == 2'd2);
    assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/tmp_readout.sv
// Counts source/sink charge packets over a fixed window and emits the sink count as a temperature code.
// Latency: the toggle that closes a window is presented on out_valid after the same edge (empty buffer).
// Backpressure: 2-entry buffer; a close arriving while full (no pop) is dropped and sets sticky ovf.
//   clk, reset          : clock, asynchronous active-high reset
//   src_tgl, snk_tgl    : controller toggle levels, each change is one packet
//   setup_bias          : holds the window clear while high
//   out_valid/out_ready : head-entry handshake; out_code, out_seq carry the entry
//   ovf                 : sticky drop flag; busy: window in progress
module tmp_readout
    import tmp_readout_pkg::*;
#(
    parameter int WINDOW = TMP_WINDOW,
    localparam int CODE_W = tmp_code_w(WINDOW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_tgl,
    input  logic              snk_tgl,
    input  logic              setup_bias,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic [3:0]        out_seq,
    output logic              ovf,
    output logic              busy
);

    localparam int CNT_W = CODE_W + 1;
    localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

    typedef struct packed {
        logic [3:0]        seq;
        logic [CODE_W-1:0] code;
    } entry_t;

    logic             r_src_q;
    logic             r_snk_q;
    logic [CNT_W-1:0] r_tot_cnt;
    logic [CNT_W-1:0] r_snk_cnt;
    logic [3:0]       r_seq_cnt;
    logic             r_ovf;

    logic             w_src_ev;
    logic             w_snk_ev;
    logic [CNT_W-1:0] w_tot_next;
    logic [CNT_W-1:0] w_tot_d;
    logic [CNT_W-1:0] w_snk_d;
    logic             w_close;
    logic [CODE_W-1:0] w_code;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    entry_t           w_wr_ent;
    entry_t           w_rd_ent;

    assign w_src_ev   = src_tgl ^ r_src_q;
    assign w_snk_ev   = snk_tgl ^ r_snk_q;
    assign w_tot_next = r_tot_cnt + CNT_W'(w_src_ev) + CNT_W'(w_snk_ev);

    // A sink event in the closing cycle always belongs to the closing window,
    // including the overshoot case where a source event lands alongside it.
    assign w_code = r_snk_cnt[CODE_W-1:0] + CODE_W'(w_snk_ev);

    always_comb begin
        w_close = 1'b0;
        w_tot_d = r_tot_cnt;
        w_snk_d = r_snk_cnt;
        if (setup_bias) begin
            w_tot_d = '0;
            w_snk_d = '0;
        end else if (w_tot_next < WIN) begin
            w_tot_d = w_tot_next;
            w_snk_d = r_snk_cnt + CNT_W'(w_snk_ev);
        end else begin
            w_close = 1'b1;
            // Overshoot by one: the source event opens the next window.
            w_tot_d = (w_tot_next == WIN) ? '0 : CNT_W'(1);
            w_snk_d = '0;
        end
    end

    assign w_pop  = out_valid && out_ready;
    assign w_push = w_close && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_q   <= 1'b0;
            r_snk_q   <= 1'b0;
            r_tot_cnt <= '0;
            r_snk_cnt <= '0;
            r_seq_cnt <= 4'd0;
            r_ovf     <= 1'b0;
        end else begin
            r_src_q   <= src_tgl;
            r_snk_q   <= snk_tgl;
            r_tot_cnt <= w_tot_d;
            r_snk_cnt <= w_snk_d;
            // Dropped windows still consume a tag so the host can see the gap.
            if (w_close) begin
                r_seq_cnt <= r_seq_cnt + 4'd1;
            end
            if (w_close && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign w_wr_ent.seq  = r_seq_cnt;
    assign w_wr_ent.code = w_code;

    tmp_readout_fifo #(
        .W ($bits(entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_dat   (w_wr_ent),
        .i_pop   (w_pop),
        .o_dat   (w_rd_ent),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = !w_empty;
    assign out_code  = w_rd_ent.code;
    assign out_seq   = w_rd_ent.seq;
    assign ovf       = r_ovf;
    assign busy      = (r_tot_cnt != '0);

endmodule

// File: tb/tb_tmp_readout.sv
module tb_tmp_readout;

    localparam int WINDOW = 8;
    localparam int CODE_W = $clog2(WINDOW + 1);

    logic              clk;
    logic              reset;
    logic              src_tgl;
    logic              snk_tgl;
    logic              setup_bias;
    logic              out_ready;
    logic              out_valid;
    logic [CODE_W-1:0] out_code;
    logic [3:0]        out_seq;
    logic              ovf;
    logic              busy;

    int checks = 0;
    int errors = 0;

    tmp_readout #(.WINDOW(WINDOW)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_tgl    (src_tgl),
        .snk_tgl    (snk_tgl),
        .setup_bias (setup_bias),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_code   (out_code),
        .out_seq    (out_seq),
        .ovf        (ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input int code, input int seq);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check({tag, ".code"}, 32'(out_code), 32'(code));
            check({tag, ".seq"}, 32'(out_seq), 32'(seq));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic s, input logic k);
        if (s) src_tgl = ~src_tgl;
        if (k) snk_tgl = ~snk_tgl;
        tick();
    endtask

    task automatic steps(input int n, input logic s, input logic k);
        for (int i = 0; i < n; i++) step(s, k);
    endtask

    initial begin
        reset      = 1'b1;
        src_tgl    = 1'b0;
        snk_tgl    = 1'b0;
        setup_bias = 1'b0;
        out_ready  = 1'b1;
        #2;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.code", 32'(out_code), 32'd0);
        check("rst.seq", 32'(out_seq), 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Window: 3 sink then 5 source, closes on the 8th toggle.
        steps(3, 1'b0, 1'b1);
        steps(4, 1'b1, 1'b0);
        check_out("w1.pre", 1'b0, 0, 0);
        check("w1.busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0);
        check_out("w1.close", 1'b1, 3, 0);
        check("w1.idle", 32'(busy), 32'd0);
        tick();
        check_out("w1.popped", 1'b0, 0, 0);

        // Simultaneous source+sink at WINDOW-1: code 2+1, source carries over.
        steps(2, 1'b0, 1'b1);
        steps(5, 1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_out("w2.close", 1'b1, 3, 1);
        check("w2.carry", 32'(busy), 32'd1);
        steps(6, 1'b1, 1'b0);
        check_out("w3.pre", 1'b0, 0, 0);
        step(1'b1, 1'b0);
        check_out("w3.close", 1'b1, 0, 2);
        tick();

        // Backpressure: fill, close with pop on full buffer, then drop.
        out_ready = 1'b0;
        steps(8, 1'b0, 1'b1);
        check_out("bp.a", 1'b1, 8, 3);
        steps(4, 1'b0, 1'b1);
        steps(4, 1'b1, 1'b0);
        check_out("bp.b_hold", 1'b1, 8, 3);
        steps(2, 1'b0, 1'b1);
        steps(5, 1'b1, 1'b0);
        out_ready = 1'b1;
        step(1'b1, 1'b0);
        out_ready = 1'b0;
        check_out("bp.full_pop", 1'b1, 4, 4);
        check("bp.no_ovf", 32'(ovf), 32'd0);
        steps(8, 1'b1, 1'b0);
        check("bp.ovf", 32'(ovf), 32'd1);
        check_out("bp.hold", 1'b1, 4, 4);
        out_ready = 1'b1;
        tick();
        check_out("bp.next", 1'b1, 2, 5);
        tick();
        check_out("bp.empty", 1'b0, 0, 0);
        step(1'b0, 1'b1);
        steps(7, 1'b1, 1'b0);
        check_out("bp.after_drop", 1'b1, 1, 7);
        tick();

        // Bias setup: toggles ignored, window restarts at zero on release.
        setup_bias = 1'b1;
        for (int i = 0; i < 20; i++) step(i[0], ~i[0]);
        check("bias.busy", 32'(busy), 32'd0);
        check_out("bias.none", 1'b0, 0, 0);
        setup_bias = 1'b0;
        steps(3, 1'b0, 1'b1);
        steps(4, 1'b1, 1'b0);
        check_out("bias.pre", 1'b0, 0, 0);
        step(1'b1, 1'b0);
        check_out("bias.close", 1'b1, 3, 8);
        tick();

        // Reset mid-window with a buffered entry.
        out_ready = 1'b0;
        steps(8, 1'b1, 1'b0);
        check_out("rw.buf", 1'b1, 0, 9);
        steps(5, 1'b0, 1'b1);
        check("rw.busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rw.valid", 32'(out_valid), 32'd0);
        check("rw.busy0", 32'(busy), 32'd0);
        check("rw.ovf0", 32'(ovf), 32'd0);
        src_tgl = 1'b0;
        snk_tgl = 1'b0;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        step(1'b0, 1'b1);
        steps(6, 1'b1, 1'b0);
        check_out("rw.pre", 1'b0, 0, 0);
        step(1'b1, 1'b0);
        check_out("rw.close", 1'b1, 1, 0);
        tick();
        check_out("rw.popped", 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmp_readout.md
# tmp_readout

Digital readout for the temperature-sensor front end. It counts charge-packet events from the sensor controller's source and sink control toggles over a fixed window of packets. At the end of each window it emits the sink-packet count as a temperature code. Results go through a 2-entry output buffer with a valid/ready handshake towards the host/register bank. It sits directly downstream of the sensor controller, in the same clock domain.

## Interface
- WINDOW, 256: total packets (source + sink) per conversion; legal range 2..4096.
- CODE_W, $clog2(WINDOW+1): code width; derived, never overridden.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- src_tgl  in  1  source-control level; every change = one source packet; synchronous to clk.
- snk_tgl  in  1  sink-control level; every change = one sink packet; synchronous to clk.
- setup_bias  in  1  high while the controller is in bias setup; window held clear.
- out_ready  in  1  host accepts head entry.
- out_valid  out  1  head entry present.
- out_code  out  CODE_W  sink packets in the completed window (0..WINDOW).
- out_seq  out  4  window sequence tag of head entry.
- ovf  out  1  sticky: a completed window was dropped because the buffer was full.
- busy  out  1  window counters non-zero.

## Operation
- Edge detect:
  - src_q/snk_q register the inputs every cycle; reset value 0.
  - src_ev = src_tgl ^ src_q; snk_ev = snk_tgl ^ snk_q.
- Counters: tot_cnt and snk_cnt, each CODE_W+1 wide; reset 0.
- While setup_bias=1:
  - tot_cnt, snk_cnt, src_q and snk_q continue tracking, but counters are forced to 0 and events are ignored.
  - The buffer, seq_cnt and ovf are untouched.
- Count and close, each cycle with setup_bias=0:
  - tot_next = tot_cnt + src_ev + snk_ev.
  - tot_next < WINDOW: tot_cnt <= tot_next; snk_cnt += snk_ev.
  - tot_next == WINDOW: close. Code = snk_cnt + snk_ev. Both counters <= 0.
  - tot_next == WINDOW+1 (simultaneous events at WINDOW-1): the sink event belongs to the closing window. Code = snk_cnt + 1. The source event carries over: tot_cnt <= 1, snk_cnt <= 0.
- Sequence tag:
  - seq_cnt, 4 bits, reset 0, increments on every close, including dropped closes.
  - It wraps 15 -> 0.
  - The entry stores the pre-increment value.
- Buffer:
  - 2-entry FIFO of {seq, code}.
  - Write on close if not full, or if full with a pop in the same cycle. Otherwise drop and set ovf.
  - ovf is cleared only by reset.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop when empty is not possible, because out_valid=0.
- busy = (tot_cnt != 0).

## Timing
- Reset values: out_valid=0, out_code=0, out_seq=0, ovf=0, busy=0. All counters and the FIFO are empty.
- An input toggle present before edge k:
  - is counted at edge k;
  - if it closes the window, out_valid is high after edge k when the buffer was empty (1-cycle latency).
- out_code/out_seq are stable while out_valid=1 && out_ready=0.
- out_ready is ignored when out_valid=0.
- After a pop at edge k, the second entry is presented after edge k, with no bubble.
- Full FIFO, close and pop in the same cycle: the push is accepted; no ovf.
- Reset mid-window: asserting reset clears everything asynchronously. The partial window is lost. The first window after release starts at 0.

## Structure
- tmp_readout_pkg:
  - WINDOW default;
  - a function giving CODE_W;
  - typedef tmp_entry_t {logic [3:0] seq; logic [CODE_W-1:0] code;}.
- Sub-module tmp_readout_fifo: 2-entry, first-word-fall-through, with push/pop/full/empty.
- Edge detect, counters and close logic live in tmp_readout.
- Expected size ~200 lines total.

## Test plan
- WINDOW=8, 3 snk toggles then 5 src toggles, one per cycle, out_ready=1 -> one entry, code=3, seq=0, out_valid high one cycle after the 8th toggle.
- WINDOW=8, 7 single toggles (2 snk), then snk and src toggle together -> code=3, seq=0. Next window starts tot=1, snk=0; 7 more src toggles -> code=0, seq=1.
- out_ready=0, three complete windows -> entries seq 0 and 1 retained, third dropped, ovf=1. Then out_ready=1 -> seq 0 then seq 1, with the next accepted entry seq=3.
- setup_bias=1 during 20 toggles, then 0 -> busy stays 0, no entries; the counting window starts from zero after release.
- Reset asserted with tot_cnt=5 and one buffered entry -> out_valid=0, busy=0, ovf=0 immediately. A fresh window produces seq=0.
